// File: rtl/alu_16b_pkg.sv
// Shared definitions for the 16-bit ALU: default data width and opcode encoding.
package alu_16b_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } opcode_e;

endpackage

// File: rtl/alu_16b_core.sv
// Combinational ALU datapath: result plus zero and negative flags.
module alu_16b_core
    import alu_16b_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [2:0]       i_opc,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    output logic [WIDTH-1:0] o_res,
    output logic             o_zer,
    output logic             o_neg
);

    logic [WIDTH-1:0] w_cin;
    logic [WIDTH-1:0] w_res;

    // Carry/borrow bit widened to the datapath width.
    assign w_cin = {{(WIDTH-1){1'b0}}, i_c};

    // Select the operation result; carry and borrow out wrap away.
    always_comb begin
        w_res = '0;
        case (i_opc)
            OP_ADD:  w_res = i_a + i_b + w_cin;
            OP_SUB:  w_res = i_a - i_b - w_cin;
            OP_AND:  w_res = i_a & i_b;
            OP_OR:   w_res = i_a | i_b;
            OP_XOR:  w_res = i_a ^ i_b;
            OP_NOT:  w_res = ~i_a;
            OP_SHL:  w_res = {i_a[WIDTH-2:0], i_c};
            OP_SHR:  w_res = {i_c, i_a[WIDTH-1:1]};
            default: w_res = '0;
        endcase
    end

    assign o_res = w_res;
    assign o_zer = (w_res == '0);
    assign o_neg = w_res[WIDTH-1];

endmodule

// File: rtl/alu_16b.sv
// 16-bit ALU top: registers the core result and its flags, synchronous reset.
module alu_16b
    import alu_16b_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       opc,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C,
    output logic [WIDTH-1:0] w,
    output logic             zer,
    output logic             neg
);

    logic [WIDTH-1:0] w_res;
    logic             w_zer;
    logic             w_neg;
    logic [WIDTH-1:0] r_w;
    logic             r_zer;
    logic             r_neg;

    alu_16b_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_opc (opc),
        .i_a   (A),
        .i_b   (B),
        .i_c   (C),
        .o_res (w_res),
        .o_zer (w_zer),
        .o_neg (w_neg)
    );

    // Output register; reset wins over the operation and leaves flags matching w=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w   <= '0;
            r_zer <= 1'b1;
            r_neg <= 1'b0;
        end else begin
            r_w   <= w_res;
            r_zer <= w_zer;
            r_neg <= w_neg;
        end
    end

    assign w   = r_w;
    assign zer = r_zer;
    assign neg = r_neg;

endmodule

// File: tb/tb_alu_16b.sv
// Self-checking bench for alu_16b: directed vector table, hand sequences, random vectors.
module tb_alu_16b;
    import alu_16b_pkg::*;

    typedef struct {
        logic        rst;
        logic [2:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] ew;
        logic        ez;
        logic        en;
    } vec_t;

    typedef struct {
        logic [15:0] w;
        logic        z;
        logic        n;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [2:0]  opc;
    logic [15:0] A;
    logic [15:0] B;
    logic        C;
    logic [15:0] w;
    logic        zer;
    logic        neg;

    int unsigned checks;
    int unsigned failures;
    exp_t        sb[$];
    vec_t        tbl[15];

    alu_16b #(
        .WIDTH (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .opc (opc),
        .A   (A),
        .B   (B),
        .C   (C),
        .w   (w),
        .zer (zer),
        .neg (neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference model using wide unsigned arithmetic.
    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic c);
        exp_t        e;
        int unsigned t;
        case (op)
            3'd0:    t = (int'(a) + int'(b) + int'(c)) % 65536;
            3'd1:    t = (65536 * 2 + int'(a) - int'(b) - int'(c)) % 65536;
            3'd2:    t = a & b;
            3'd3:    t = a | b;
            3'd4:    t = a ^ b;
            3'd5:    t = 65535 - int'(a);
            3'd6:    t = ((int'(a) * 2) % 65536) + int'(c);
            default: t = (int'(a) / 2) + (c ? 32768 : 0);
        endcase
        e.w = t[15:0];
        e.z = (t == 0);
        e.n = (t >= 32768);
        return e;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic apply(input string name, input logic r, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic c,
                         input exp_t e);
        exp_t got;
        @(negedge clk);
        rst = r; opc = op; A = a; B = b; C = c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            got = sb.pop_front();
            check({name, ".w"},   w,           got.w);
            check({name, ".zer"}, {15'd0, zer}, {15'd0, got.z});
            check({name, ".neg"}, {15'd0, neg}, {15'd0, got.n});
        end
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; opc = 3'd0; A = '0; B = '0; C = 1'b0;
        checks = 0; failures = 0;

        tbl[0]  = '{1'b1, OP_ADD, 16'h1234, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, OP_ADD, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, OP_SUB, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, OP_SUB, 16'h0005, 16'h0007, 1'b1, 16'hFFFD, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, OP_XOR, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, OP_AND, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, OP_NOT, 16'h0000, 16'h5555, 1'b1, 16'hFFFF, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, OP_SHL, 16'h8001, 16'hFFFF, 1'b1, 16'h0003, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, OP_SHR, 16'h8001, 16'hFFFF, 1'b0, 16'h4000, 1'b0, 1'b0};
        tbl[10] = '{1'b0, OP_SHR, 16'h0001, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
        tbl[11] = '{1'b0, OP_OR,  16'h1200, 16'h0034, 1'b1, 16'h1234, 1'b0, 1'b0};
        tbl[12] = '{1'b0, OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[13] = '{1'b1, OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[14] = '{1'b0, OP_ADD, 16'h0001, 16'h0001, 1'b1, 16'h0003, 1'b0, 1'b0};

        for (int i = 0; i < 15; i++) begin
            e.w = tbl[i].ew; e.z = tbl[i].ez; e.n = tbl[i].en;
            apply($sformatf("vec%0d", i), tbl[i].rst, tbl[i].opc, tbl[i].a,
                  tbl[i].b, tbl[i].c, e);
        end

        // Inputs changing between edges must not reach the outputs.
        e.w = 16'h0002; e.z = 1'b0; e.n = 1'b0;
        apply("hold_base", 1'b0, OP_ADD, 16'h0001, 16'h0001, 1'b0, e);
        opc = OP_NOT; A = 16'h0000; C = 1'b1;
        #2;
        check("hold_mid.w",   w,            16'h0002);
        check("hold_mid.zer", {15'd0, zer}, 16'h0000);

        // Two consecutive reset cycles, then resume with the next sampled inputs.
        e.w = 16'h0000; e.z = 1'b1; e.n = 1'b0;
        apply("rst_a", 1'b1, OP_NOT, 16'h0000, 16'h0000, 1'b0, e);
        apply("rst_b", 1'b1, OP_NOT, 16'h0000, 16'h0000, 1'b0, e);
        e.w = 16'hFFFF; e.z = 1'b0; e.n = 1'b1;
        apply("resume", 1'b0, OP_NOT, 16'h0000, 16'h0000, 1'b0, e);

        // Random vectors, each held for 1..3 cycles.
        for (int k = 0; k < 16; k++) begin
            logic [2:0]  rop;
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rc;
            int unsigned hold;
            rop  = 3'($urandom_range(0, 7));
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 3);
            e = model(rop, ra, rb, rc);
            for (int h = 0; h < int'(hold); h++)
                apply($sformatf("rnd%0d_op%0d", k, rop), 1'b0, rop, ra, rb, rc, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_16b.md
ALU_16B -- requirements
Module: alu_16b

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width of A, B and w; all values in this document assume 16.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port opc, input, 3 bits: operation select.
REQ-005 SHALL have port A, input, WIDTH bits: first operand.
REQ-006 SHALL have port B, input, WIDTH bits: second operand.
REQ-007 SHALL have port C, input, 1 bit: carry-in, borrow-in, or shift-in bit.
REQ-008 SHALL have port w, output, WIDTH bits: registered result.
REQ-009 SHALL have port zer, output, 1 bit: registered zero flag.
REQ-010 SHALL have port neg, output, 1 bit: registered negative flag.

Function
REQ-011 SHALL compute the result combinationally from opc, A, B and C, and register it into w on each rising clk edge when rst=0; latency is 1 cycle and there is no handshake.
REQ-012 SHALL implement opc=000 ADD: w = (A + B + C) mod 2^16; carry-out is discarded.
REQ-013 SHALL implement opc=001 SUB: w = (A - B - C) mod 2^16; borrow-out is discarded.
REQ-014 SHALL implement opc=010 AND: w = A & B; C is ignored.
REQ-015 SHALL implement opc=011 OR: w = A | B; C is ignored.
REQ-016 SHALL implement opc=100 XOR: w = A ^ B; C is ignored.
REQ-017 SHALL implement opc=101 NOT: w = ~A; B and C are ignored.
REQ-018 SHALL implement opc=110 SHL: w = {A[14:0], C}; B is ignored.
REQ-019 SHALL implement opc=111 SHR: w = {C, A[15:1]}; B is ignored.
REQ-020 SHALL register zer = 1 exactly when the registered w equals 0, in the same cycle as w.
REQ-021 SHALL register neg = the MSB of the registered w, in the same cycle as w.
REQ-022 SHALL keep zer and neg consistent with w at all times, including immediately after reset.
REQ-023 SHALL treat operands as two's-complement for neg only; overflow SHALL wrap silently with no overflow flag.
REQ-024 SHALL produce an output value only for inputs sampled at a clock edge; input changes between edges SHALL have no effect on the outputs.
REQ-025 SHALL produce no X on any output when all inputs are known.

Reset
REQ-026 SHALL, on a rising clk edge with rst=1, set w=16'h0000, zer=1 and neg=0.
REQ-027 SHALL give rst priority over any operation presented in the same cycle; that operation's result is discarded.
REQ-028 SHALL resume normal operation on the first rising edge with rst=0, registering the inputs present at that edge.

Structure
REQ-029 SHALL place in a shared package alu_16b_pkg: the opcode enum (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR; 3 bits) and the WIDTH default constant.
REQ-030 SHALL place the combinational datapath (result, zero and negative computation) in one sub-module alu_16b_core, with alu_16b adding the output registers and reset.

Verification
REQ-031 SHALL check reset: rst=1 for 1 cycle with opc=000, A=16'h1234, B=16'h0001 -> w=16'h0000, zer=1, neg=0; result unaffected by the operation.
REQ-032 SHALL check ADD: A=16'h7FFF, B=16'h0001, C=0 -> next cycle w=16'h8000, neg=1, zer=0; then A=16'hFFFF, B=16'h0000, C=1 -> w=16'h0000, zer=1, neg=0 (wrap).
REQ-033 SHALL check SUB: A=16'h0005, B=16'h0007, C=0 -> w=16'hFFFE, neg=1; same operands with C=1 -> w=16'hFFFD.
REQ-034 SHALL check logic ops: A=B=16'h1234 with XOR -> w=16'h0000, zer=1; AND of A=16'hF0F0, B=16'h0FF0 -> w=16'h00F0; NOT of A=16'h0000 -> w=16'hFFFF, neg=1.
REQ-035 SHALL check shifts: SHL with A=16'h8001, C=1 -> w=16'h0003; SHR with A=16'h8001, C=0 -> w=16'h4000; SHR with A=16'h0001, C=1 -> w=16'h8000, neg=1.
REQ-036 SHALL run at least 10 random opc/A/B/C vectors, each held for 1 or more cycles, comparing w, zer and neg against a reference model one cycle later.
